// File: rtl/a2d_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : a2d_pkg
//  Purpose  : Shared types and constants for the A2D SPI conversion responder.
//             Holds the FSM state encoding, divider preload, transfer width
//             and the command-word builder used by both transactions.
//  Ports    : none (package)
//  Revision : 1.0  initial release
// ============================================================================
package a2d_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        XFER1 = 2'd1,
        GAP   = 2'd2,
        XFER2 = 2'd3
    } state_t;

    localparam int XFER_BITS  = 16;
    localparam int RES_BITS   = 12;
    localparam int CHNNL_BITS = 3;

    // Command word layout: {CMD_HI_PAD zeros, channel, CMD_LO_PAD zeros}
    localparam int CMD_HI_PAD = 2;
    localparam int CMD_LO_PAD = 11;

    // Preload places the first SCLK fall 9 clk after SS_n asserts.
    localparam logic [4:0] DIV_PRELOAD = 5'b10111;

    function automatic logic [XFER_BITS-1:0] make_cmd(input logic [CHNNL_BITS-1:0] ch);
        return {{CMD_HI_PAD{1'b0}}, ch, {CMD_LO_PAD{1'b0}}};
    endfunction

endpackage
`default_nettype wire

// File: rtl/a2d_spi_phy.sv
`default_nettype none
// ============================================================================
//  Module   : a2d_spi_phy
//  Purpose  : 16-bit SPI master bit engine. Owns the SCLK divider, the MISO
//             sample flop, the shift register and the rise counter. One
//             transaction runs per start pulse; done pulses combinationally
//             on the edge that performs the final shift and releases SS_n.
//  Ports    : clk, rst        - clock, async active-high reset
//             start, cmd      - begin transaction, word to transmit
//             done            - last cycle of transaction (same-edge strobe)
//             rx_word         - low bits of the post-final-shift receive word
//             sclk, mosi,     - SPI pins
//             ss_n, miso
//  Revision : 1.0  initial release
// ============================================================================
module a2d_spi_phy
    import a2d_pkg::*;
#(
    parameter int SCLK_DIV_W = 5
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [XFER_BITS-1:0] cmd,
    output logic                 done,
    output logic [RES_BITS-1:0]  rx_word,
    output logic                 sclk,
    output logic                 mosi,
    output logic                 ss_n,
    input  logic                 miso
);

    localparam int                    c_cnt_w       = $clog2(XFER_BITS + 1);
    localparam logic [SCLK_DIV_W-1:0] c_div_preload = SCLK_DIV_W'(DIV_PRELOAD);
    localparam logic [SCLK_DIV_W-1:0] c_div_rise    = {1'b0, {(SCLK_DIV_W-1){1'b1}}};
    localparam logic [SCLK_DIV_W-1:0] c_div_fall    = {SCLK_DIV_W{1'b1}};
    localparam logic [c_cnt_w-1:0]    c_rise_last   = c_cnt_w'(XFER_BITS);

    logic [SCLK_DIV_W-1:0] r_div;
    logic [XFER_BITS-1:0]  r_shreg;
    logic                  r_sample;
    logic [c_cnt_w-1:0]    r_rise_cnt;
    logic                  r_ss_n;

    logic                  w_rise;
    logic                  w_fall;
    logic                  w_last;
    logic [XFER_BITS-1:0]  w_shifted;

    assign w_rise    = ~r_ss_n && (r_div == c_div_rise);
    assign w_fall    = ~r_ss_n && (r_div == c_div_fall);
    assign w_last    = w_fall && (r_rise_cnt == c_rise_last);
    assign w_shifted = {r_shreg[XFER_BITS-2:0], r_sample};

    assign done    = w_last;
    assign rx_word = w_shifted[RES_BITS-1:0];
    assign sclk    = r_div[SCLK_DIV_W-1];
    assign mosi    = r_shreg[XFER_BITS-1];
    assign ss_n    = r_ss_n;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_div      <= c_div_preload;
            r_shreg    <= '0;
            r_sample   <= 1'b0;
            r_rise_cnt <= '0;
            r_ss_n     <= 1'b1;
        end else if (start) begin
            r_shreg    <= cmd;
            r_ss_n     <= 1'b0;
            r_div      <= c_div_preload;
            r_rise_cnt <= '0;
        end else if (r_ss_n) begin
            r_div <= c_div_preload;
        end else begin
            r_div <= r_div + 1'b1;
            if (w_rise) begin
                r_sample   <= miso;
                r_rise_cnt <= r_rise_cnt + 1'b1;
            end
            // The very first fall has no captured bit behind it, so skip it.
            if (w_fall && (r_rise_cnt != '0)) begin
                r_shreg <= w_shifted;
            end
            if (w_last) begin
                r_ss_n <= 1'b1;
                r_div  <= c_div_preload;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/a2d_spi_intf.sv
`default_nettype none
// ============================================================================
//  Module   : a2d_spi_intf
//  Purpose  : Conversion responder between the motion controller and an
//             external SPI ADC. A request runs two SPI transactions carrying
//             the channel command; the second returns the 12-bit result,
//             published with cnv_cmplt.
//  Ports    : clk, rst          - clock, async active-high reset
//             strt_cnv, chnnl   - conversion request and channel
//             cnv_cmplt, res    - completion flag and result
//             a2d_SS_n, SCLK,   - ADC SPI pins
//             MOSI, MISO
//  Revision : 1.0  initial release
// ============================================================================
module a2d_spi_intf
    import a2d_pkg::*;
#(
    parameter int SCLK_DIV_W = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  strt_cnv,
    input  logic [CHNNL_BITS-1:0] chnnl,
    output logic                  cnv_cmplt,
    output logic [RES_BITS-1:0]   res,
    output logic                  a2d_SS_n,
    output logic                  SCLK,
    output logic                  MOSI,
    input  logic                  MISO
);

    state_t                r_state;
    logic [CHNNL_BITS-1:0] r_chnnl;

    logic                  w_start;
    logic                  w_done;
    logic [XFER_BITS-1:0]  w_cmd;
    logic [RES_BITS-1:0]   w_rx;

    // In IDLE the command is built from the live channel so it is ready on
    // the accepting edge; the second transaction uses the latched copy.
    assign w_start = ((r_state == IDLE) && strt_cnv) || (r_state == GAP);
    assign w_cmd   = make_cmd((r_state == IDLE) ? chnnl : r_chnnl);

    a2d_spi_phy #(
        .SCLK_DIV_W (SCLK_DIV_W)
    ) u_phy (
        .clk     (clk),
        .rst     (rst),
        .start   (w_start),
        .cmd     (w_cmd),
        .done    (w_done),
        .rx_word (w_rx),
        .sclk    (SCLK),
        .mosi    (MOSI),
        .ss_n    (a2d_SS_n),
        .miso    (MISO)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= IDLE;
            r_chnnl   <= '0;
            res       <= '0;
            cnv_cmplt <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (strt_cnv) begin
                        r_chnnl   <= chnnl;
                        cnv_cmplt <= 1'b0;
                        r_state   <= XFER1;
                    end
                end
                XFER1: begin
                    if (w_done) begin
                        r_state <= GAP;
                    end
                end
                GAP: begin
                    r_state <= XFER2;
                end
                XFER2: begin
                    if (w_done) begin
                        res       <= w_rx;
                        cnv_cmplt <= 1'b1;
                        r_state   <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_a2d_spi_intf.sv
`default_nettype none
// ============================================================================
//  Module   : tb_a2d_spi_intf
//  Purpose  : Self-checking bench for a2d_spi_intf with a behavioural SPI ADC
//             model recording MOSI words, SCLK rises and SS_n timing.
//  Revision : 1.0  initial release
// ============================================================================
module tb_a2d_spi_intf;

    logic        clk = 1'b0;
    logic        rst;
    logic        strt_cnv;
    logic [2:0]  chnnl;
    logic        cnv_cmplt;
    logic [11:0] res;
    logic        a2d_SS_n;
    logic        SCLK;
    logic        MOSI;
    logic        MISO = 1'b0;

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;

    a2d_spi_intf #(.SCLK_DIV_W(5)) dut (
        .clk       (clk),
        .rst       (rst),
        .strt_cnv  (strt_cnv),
        .chnnl     (chnnl),
        .cnv_cmplt (cnv_cmplt),
        .res       (res),
        .a2d_SS_n  (a2d_SS_n),
        .SCLK      (SCLK),
        .MOSI      (MOSI),
        .MISO      (MISO)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    // ---------------- behavioural ADC ----------------
    logic [15:0] adc_q[$];
    logic [15:0] cur_word  = 16'h0;
    logic [15:0] mosi_sh   = 16'h0;
    int          bit_idx   = 15;
    int          rises     = 0;
    bit          first_seen = 1'b0;
    int          fall_cyc_q[$];
    int          rise_cyc_q[$];
    int          first_fall_q[$];
    int          rises_q[$];
    logic [15:0] mosi_q[$];

    always @(negedge a2d_SS_n) begin
        fall_cyc_q.push_back(cyc);
        cur_word   = (adc_q.size() > 0) ? adc_q.pop_front() : 16'h0;
        bit_idx    = 15;
        MISO       = cur_word[15];
        rises      = 0;
        mosi_sh    = 16'h0;
        first_seen = 1'b0;
    end

    always @(posedge a2d_SS_n) begin
        if (fall_cyc_q.size() > rise_cyc_q.size()) begin
            rise_cyc_q.push_back(cyc);
            mosi_q.push_back(mosi_sh);
            rises_q.push_back(rises);
        end
    end

    always @(posedge SCLK) begin
        if (a2d_SS_n === 1'b0) begin
            mosi_sh = {mosi_sh[14:0], MOSI};
            rises++;
        end
    end

    always @(negedge SCLK) begin
        if (a2d_SS_n === 1'b0) begin
            if (!first_seen) begin
                first_seen = 1'b1;
                first_fall_q.push_back(cyc);
            end
            if (rises > 0 && bit_idx > 0) begin
                bit_idx--;
                MISO = cur_word[bit_idx];
            end
        end
    end

    // ---------------- checking helpers ----------------
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] cmd_of(input logic [2:0] ch);
        return 16'(ch) * 16'd2048;   // channel sits at bits 13:11
    endfunction

    // Drive a request at a negedge; returns the accepting-edge cycle number.
    task automatic start_conv(input logic [2:0] ch, input bit hold, output int c0, output int b);
        @(negedge clk);
        b        = fall_cyc_q.size();
        strt_cnv = 1'b1;
        chnnl    = ch;
        @(posedge clk);
        #1;
        c0 = cyc;
        @(negedge clk);
        if (!hold) strt_cnv = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int c0, input logic [11:0] exp_res);
        bit ok = 1'b0;
        for (int i = 0; i < 1200; i++) begin
            if (cnv_cmplt === 1'b1) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        chk({tag, "_done"}, 32'(ok), 32'd1);
        chk({tag, "_latency"}, 32'(cyc - c0), 32'd1043);
        chk({tag, "_res"}, 32'(res), 32'(exp_res));
    endtask

    task automatic check_records(input string tag, input int b, input logic [2:0] ch);
        int n;
        n = (mosi_q.size() < first_fall_q.size()) ? mosi_q.size() : first_fall_q.size();
        if (n < b + 2) begin
            chk({tag, "_records"}, 32'(n), 32'(b + 2));
        end else begin
            for (int t = 0; t < 2; t++) begin
                chk({tag, $sformatf("_mosi%0d", t)}, 32'(mosi_q[b+t]), 32'(cmd_of(ch)));
                chk({tag, $sformatf("_rises%0d", t)}, 32'(rises_q[b+t]), 32'd16);
                chk({tag, $sformatf("_sslow%0d", t)}, 32'(rise_cyc_q[b+t] - fall_cyc_q[b+t]), 32'd521);
                chk({tag, $sformatf("_porch%0d", t)}, 32'(first_fall_q[b+t] - fall_cyc_q[b+t]), 32'd9);
            end
            chk({tag, "_gap"}, 32'(fall_cyc_q[b+1] - rise_cyc_q[b]), 32'd1);
        end
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int          c0, b, ca, ba, target;
        logic [2:0]  ch;
        logic [15:0] w1, w2;
        bit          ok;

        rst      = 1'b1;
        strt_cnv = 1'b0;
        chnnl    = 3'd0;
        repeat (3) @(negedge clk);
        chk("rst_cmplt", 32'(cnv_cmplt), 32'd0);
        chk("rst_res",   32'(res),       32'd0);
        chk("rst_ssn",   32'(a2d_SS_n),  32'd1);
        chk("rst_sclk",  32'(SCLK),      32'd1);
        chk("rst_mosi",  32'(MOSI),      32'd0);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("idle_ssn", 32'(a2d_SS_n), 32'd1);

        // Spec example: channel 5, result 0xABC
        adc_q.push_back(16'($urandom));
        adc_q.push_back(16'h0ABC);
        start_conv(3'd5, 1'b0, c0, b);
        wait_done("ch5", c0, 12'hABC);
        check_records("ch5", b, 3'd5);

        // strt_cnv held high, chnnl toggled: one conversion on channel 3,
        // then a second accepted on the first IDLE cycle.
        adc_q.push_back(16'h1111);
        adc_q.push_back(16'h7123);
        adc_q.push_back(16'h2222);
        adc_q.push_back(16'h9456);
        start_conv(3'd3, 1'b1, c0, b);
        ok = 1'b0;
        for (int i = 0; i < 1200; i++) begin
            if (cnv_cmplt === 1'b1) begin
                ok = 1'b1;
                break;
            end
            chnnl = 3'($urandom);
            @(negedge clk);
        end
        chk("hold_done", 32'(ok), 32'd1);
        chk("hold_latency", 32'(cyc - c0), 32'd1043);
        chk("hold_res", 32'(res), 32'h123);
        chk("hold_ntx", 32'(fall_cyc_q.size() - b), 32'd2);
        chnnl = 3'd6;
        @(negedge clk);
        strt_cnv = 1'b0;
        chk("hold_restart_cmplt", 32'(cnv_cmplt), 32'd0);
        chk("hold_restart_ssn", 32'(a2d_SS_n), 32'd0);
        check_records("hold", b, 3'd3);
        wait_done("hold2", c0 + 1044, 12'h456);
        check_records("hold2", b + 2, 3'd6);

        // Reset 300 clk into XFER2
        adc_q.push_back(16'h0F0F);
        adc_q.push_back(16'h0A5A);
        start_conv(3'd2, 1'b0, c0, b);
        target = c0 + 522 + 300;
        for (int i = 0; i < 1200 && cyc < target; i++) @(negedge clk);
        #1 rst = 1'b1;
        #1;
        chk("mid_rst_ssn",   32'(a2d_SS_n),  32'd1);
        chk("mid_rst_sclk",  32'(SCLK),      32'd1);
        chk("mid_rst_cmplt", 32'(cnv_cmplt), 32'd0);
        chk("mid_rst_res",   32'(res),       32'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (1200) @(negedge clk);
        chk("post_rst_cmplt", 32'(cnv_cmplt), 32'd0);
        chk("post_rst_res",   32'(res),       32'd0);
        chk("post_rst_ssn",   32'(a2d_SS_n),  32'd1);
        adc_q.delete();
        adc_q.push_back(16'h0000);
        adc_q.push_back(16'h0321);
        start_conv(3'd1, 1'b0, c0, b);
        wait_done("after_rst", c0, 12'h321);
        check_records("after_rst", b, 3'd1);

        // Back-to-back ch0 then ch7; upper nibble of the MISO word is noise
        adc_q.push_back(16'($urandom));
        adc_q.push_back({4'($urandom), 12'hFFF});
        start_conv(3'd0, 1'b0, ca, ba);
        wait_done("b2b0", ca, 12'hFFF);
        check_records("b2b0", ba, 3'd0);
        adc_q.push_back(16'($urandom));
        adc_q.push_back({4'($urandom), 12'h001});
        start_conv(3'd7, 1'b0, c0, b);
        chk("b2b_clear", 32'(cnv_cmplt), 32'd0);
        chk("b2b_hold_res", 32'(res), 32'hFFF);
        wait_done("b2b7", c0, 12'h001);
        check_records("b2b7", b, 3'd7);

        // Randomized conversions
        for (int k = 0; k < 4; k++) begin
            ch = 3'($urandom);
            w1 = 16'($urandom);
            w2 = 16'($urandom);
            adc_q.push_back(w1);
            adc_q.push_back(w2);
            repeat ($urandom_range(1, 5)) @(negedge clk);
            start_conv(ch, 1'b0, c0, b);
            wait_done($sformatf("rnd%0d", k), c0, w2[11:0]);
            check_records($sformatf("rnd%0d", k), b, ch);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
